// File: rtl/and_share_arbiter_if.sv
// Handshake/data bundle between the requesters and the shared AND unit.
//   req  : per-requester request level
//   a0   : operand A, requester i at [i*WIDTH +: WIDTH]
//   a1   : operand B, same packing
//   ack  : consumer accepts the result while done=1
//   gnt  : one-hot, one-cycle grant pulse
//   busy : arbiter not idle
//   done : result valid, held until ack
//   id   : requester that owns x
//   x    : captured a0 & captured a1
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface and_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a0;
  logic [NREQ*WIDTH-1:0] a1;
  logic                  ack;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        id;
  logic [WIDTH-1:0]      x;

  modport master (output req, a0, a1, ack, input gnt, busy, done, id, x);
  modport slave  (input req, a0, a1, ack, output gnt, busy, done, id, x);
endinterface

// File: rtl/and_share_arbiter.sv
// Shares one registered bitwise 2-input AND among NREQ requesters with
// round-robin arbitration. Operands are captured at the grant edge, the
// result is evaluated one cycle later and held until the consumer acks.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : and_share_arbiter_if slave modport (req/a0/a1/ack in,
//           gnt/busy/done/id/x out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for any req; grants the winner and captures its operands
// EVAL  | computes x from the captured operands, raises done
// RESP  | result presented; leaves on ack and advances the rr pointer
module and_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  and_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;

  logic [IDW-1:0]   win;
  logic             found;
  int               idx;

  // First set req bit searching ptr, ptr+1, ... with wrap at NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    done_d  = done_q;
    id_d    = id_q;
    x_d     = x_q;
    cap_a_d = cap_a_q;
    cap_b_d = cap_b_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          cap_a_d    = bus.a0[win*WIDTH +: WIDTH];
          cap_b_d    = bus.a1[win*WIDTH +: WIDTH];
          id_d       = win;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        x_d     = cap_a_q & cap_b_q;
        done_d  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.ack) begin
          done_d  = 1'b0;
          // Owner just served drops to lowest priority.
          ptr_d   = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      id_q    <= '0;
      x_q     <= '0;
      cap_a_q <= '0;
      cap_b_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      id_q    <= id_d;
      x_q     <= x_d;
      cap_a_q <= cap_a_d;
      cap_b_q <= cap_b_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.id   = id_q;
  assign bus.x    = x_q;

endmodule

// File: tb/tb_and_share_arbiter.sv
// Directed bench for and_share_arbiter (NREQ=4, WIDTH=8).
module tb_and_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  and_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  and_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Expected results for a0=12_34_56_78, a1=FF_0F_F0_33, requesters 0..3.
  logic [7:0] exp_x [4];

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    exp_x[0] = 8'h30;
    exp_x[1] = 8'h50;
    exp_x[2] = 8'h04;
    exp_x[3] = 8'h12;
    bus.req = '0;
    bus.a0  = '0;
    bus.a1  = '0;
    bus.ack = 1'b0;
    rst_n   = 1'b1;
    do_reset();

    check_vec("rst_gnt", 32'(bus.gnt), 32'h0);
    check_vec("rst_busy", 32'(bus.busy), 32'h0);
    check_vec("rst_done", 32'(bus.done), 32'h0);
    check_vec("rst_id", 32'(bus.id), 32'h0);
    check_vec("rst_x", 32'(bus.x), 32'h0);

    // Single op plus 5-cycle hold in RESP.
    bus.a0[7:0] = 8'hF0;
    bus.a1[7:0] = 8'h3C;
    bus.req     = 4'b0001;
    step();
    check_vec("single_gnt", 32'(bus.gnt), 32'h1);
    check_vec("single_busy", 32'(bus.busy), 32'h1);
    check_vec("single_done_early", 32'(bus.done), 32'h0);
    bus.req = '0;
    step();
    check_vec("single_done", 32'(bus.done), 32'h1);
    check_vec("single_x", 32'(bus.x), 32'h30);
    check_vec("single_id", 32'(bus.id), 32'h0);
    check_vec("single_gnt_off", 32'(bus.gnt), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_vec("hold_done", 32'(bus.done), 32'h1);
      check_vec("hold_x", 32'(bus.x), 32'h30);
      check_vec("hold_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.ack = 1'b1;
    step();
    check_vec("hold_ack_done", 32'(bus.done), 32'h0);
    check_vec("hold_ack_busy", 32'(bus.busy), 32'h0);

    // Round robin from ptr=0, ack tied high, gnt every 3 cycles.
    do_reset();
    bus.a0  = 32'h12_34_56_78;
    bus.a1  = 32'hFF_0F_F0_33;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check_vec("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
      check_vec("rr_id", 32'(bus.id), 32'(k % 4));
      if (k == 4) bus.req = '0;
      step();
      check_vec("rr_gnt_off", 32'(bus.gnt), 32'h0);
      check_vec("rr_x", 32'(bus.x), 32'(exp_x[k % 4]));
      check_vec("rr_done", 32'(bus.done), 32'h1);
      step();
      check_vec("rr_idle", 32'(bus.busy), 32'h0);
      check_vec("rr_gnt_idle", 32'(bus.gnt), 32'h0);
    end

    // Operand sampling: ptr=1, request 2, change its a0 after grant.
    bus.req = 4'b0100;
    step();
    check_vec("samp_gnt", 32'(bus.gnt), 32'h4);
    bus.req       = '0;
    bus.a0[23:16] = 8'hFF;
    step();
    check_vec("samp_x", 32'(bus.x), 32'h04);
    check_vec("samp_id", 32'(bus.id), 32'h2);
    step();
    check_vec("samp_idle", 32'(bus.busy), 32'h0);

    // Wrap/dropout: ptr=3, req 3 and 0 and 1, drop 1 before its turn.
    bus.req = 4'b1011;
    step();
    check_vec("wrap_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0011;
    step();
    check_vec("wrap_x3", 32'(bus.x), 32'h12);
    bus.req = 4'b0001;
    step();
    check_vec("wrap_idle", 32'(bus.busy), 32'h0);
    step();
    check_vec("wrap_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    step();
    check_vec("wrap_x0", 32'(bus.x), 32'h30);
    for (int i = 0; i < 4; i++) begin
      step();
      check_vec("drop_gnt", 32'(bus.gnt), 32'h0);
    end
    check_vec("drop_busy", 32'(bus.busy), 32'h0);

    // Reset mid-EVAL discards the op.
    bus.req = 4'b0010;
    step();
    check_vec("mid_gnt", 32'(bus.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check_vec("mid_rst_done", 32'(bus.done), 32'h0);
    check_vec("mid_rst_x", 32'(bus.x), 32'h0);
    check_vec("mid_rst_id", 32'(bus.id), 32'h0);
    check_vec("mid_rst_busy", 32'(bus.busy), 32'h0);
    bus.req = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_vec("post_rst_done", 32'(bus.done), 32'h0);
      check_vec("post_rst_busy", 32'(bus.busy), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
